// File: rtl/vec_issue_ctrl.sv
// vec_issue_ctrl
// Issue controller for a single in-order vector execute unit.
// Accepts decoded vector instructions, blocks on RAW/WAW hazards through an
// 8-entry register scoreboard, issues with zero latency to the execute unit,
// and tracks in-flight ops in an in-order tag FIFO so that each ex_done maps to
// the oldest outstanding op for writeback. A flush request stops acceptance and
// waits for in-flight ops to drain, then pulses flush_done.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   in_valid / in_ready           instruction handshake
//   in_vd, in_vs1, in_vs2, in_we  register indices and write flag
//   in_alu_op                     opcode
//   ex_valid, ex_alu_op,
//   ex_vs1, ex_vs2                issue strobe and operands to execute unit
//   ex_busy                       execute unit cannot accept this cycle
//   ex_done                       one in-order completion this cycle
//   wb_we, wb_vd                  register-file writeback for the completing op
//   flush_req / flush_done        drain request and one-cycle drained pulse
//   sb_busy                       pending-write bitmap, bit i = v[i]
//   stall_cnt                     saturating count of stalled valid cycles
//   err_underflow                 sticky: ex_done seen with nothing in flight
module vec_issue_ctrl #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_vd,
    input  logic [2:0]       in_vs1,
    input  logic [2:0]       in_vs2,
    input  logic             in_we,
    input  logic [2:0]       in_alu_op,
    output logic             ex_valid,
    output logic [2:0]       ex_alu_op,
    output logic [2:0]       ex_vs1,
    output logic [2:0]       ex_vs2,
    input  logic             ex_busy,
    input  logic             ex_done,
    output logic             wb_we,
    output logic [2:0]       wb_vd,
    input  logic             flush_req,
    output logic             flush_done,
    output logic [7:0]       sb_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             err_underflow
);

    localparam int PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int CW = $clog2(MAX_INFLIGHT) + 1;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  count;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [2:0]     tag_vd [MAX_INFLIGHT];
    logic           tag_we [MAX_INFLIGHT];

    logic           hazard;
    logic           issue;
    logic           pop;
    logic [7:0]     sb_nxt;

    // Hazards are judged against the registered scoreboard only; a completion
    // in the same cycle does not release a waiting instruction until next cycle.
    assign hazard = sb_busy[in_vs1] | sb_busy[in_vs2] | (in_we & sb_busy[in_vd]);

    assign in_ready = (state == RUN) & ~flush_req & ~hazard & ~ex_busy
                    & (count < CW'(MAX_INFLIGHT));
    assign issue    = in_valid & in_ready;

    assign ex_valid  = issue;
    assign ex_alu_op = in_alu_op;
    assign ex_vs1    = in_vs1;
    assign ex_vs2    = in_vs2;

    // A completion with nothing in flight is dropped and only flags an error.
    assign pop   = ex_done & (count != '0);
    assign wb_vd = tag_vd[rd_ptr];
    assign wb_we = pop & tag_we[rd_ptr];

    // Clear for the completing op first, then set for the issuing op, so a
    // same-index collision leaves the bit set for the new writer.
    always_comb begin
        sb_nxt = sb_busy;
        if (wb_we)
            sb_nxt[wb_vd] = 1'b0;
        if (issue && in_we)
            sb_nxt[in_vd] = 1'b1;
    end

    // Flush FSM
    always_comb begin
        state_nxt  = state;
        flush_done = 1'b0;
        case (state)
            RUN:   if (flush_req) state_nxt = DRAIN;
            DRAIN: if (count == '0) state_nxt = DONE;
            DONE: begin
                flush_done = 1'b1;
                state_nxt  = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // Tag FIFO and in-flight count. Depth is a power of two, so the pointers
    // wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                tag_vd[i] <= '0;
                tag_we[i] <= 1'b0;
            end
        end else begin
            if (issue) begin
                tag_vd[wr_ptr] <= in_vd;
                tag_we[wr_ptr] <= in_we;
                wr_ptr         <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (issue && !pop)
                count <= count + CW'(1);
            else if (pop && !issue)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sb_busy <= '0;
        else
            sb_busy <= sb_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt     <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (in_valid && !in_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (ex_done && (count == '0))
                err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Directed bench for vec_issue_ctrl. A queue-based model of the in-flight ops
// predicts every output each cycle; the directed sequence also pins a few
// hand-computed values.
module tb_vec_issue_ctrl;

    localparam int MAXF  = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready;
    logic [2:0]       in_vd, in_vs1, in_vs2, in_alu_op;
    logic             in_we;
    logic             ex_valid;
    logic [2:0]       ex_alu_op, ex_vs1, ex_vs2;
    logic             ex_busy, ex_done;
    logic             wb_we;
    logic [2:0]       wb_vd;
    logic             flush_req, flush_done;
    logic [7:0]       sb_busy;
    logic [CNT_W-1:0] stall_cnt;
    logic             err_underflow;

    int errors = 0;
    int checks = 0;

    vec_issue_ctrl #(.MAX_INFLIGHT(MAXF), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2),
        .in_we(in_we), .in_alu_op(in_alu_op),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_vs1(ex_vs1), .ex_vs2(ex_vs2),
        .ex_busy(ex_busy), .ex_done(ex_done),
        .wb_we(wb_we), .wb_vd(wb_vd),
        .flush_req(flush_req), .flush_done(flush_done),
        .sb_busy(sb_busy), .stall_cnt(stall_cnt),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int q_vd[$];
    bit q_we[$];
    int m_phase;      // 0 accepting, 1 waiting to drain, 2 drained pulse
    int m_stall;
    bit m_err;

    function automatic logic [7:0] m_sb();
        logic [7:0] r = '0;
        foreach (q_vd[i]) if (q_we[i]) r[q_vd[i]] = 1'b1;
        return r;
    endfunction

    always @(negedge clk) begin : cmp
        logic [7:0] sb;
        bit hz, rdy, iss, pp;
        int sz;
        if (!rst_n) begin
            q_vd.delete(); q_we.delete();
            m_phase = 0; m_stall = 0; m_err = 0;
        end
        sb  = m_sb();
        sz  = q_vd.size();
        hz  = sb[in_vs1] | sb[in_vs2] | (in_we & sb[in_vd]);
        rdy = (m_phase == 0) && !flush_req && !hz && !ex_busy && (sz < MAXF);
        iss = in_valid && rdy;
        pp  = ex_done && (sz > 0);

        chk("m_in_ready", in_ready, rdy);
        chk("m_ex_valid", ex_valid, iss);
        if (iss) begin
            chk("m_ex_alu_op", ex_alu_op, in_alu_op);
            chk("m_ex_vs1", ex_vs1, in_vs1);
            chk("m_ex_vs2", ex_vs2, in_vs2);
        end
        chk("m_wb_we", wb_we, pp && q_we[0]);
        if (pp) chk("m_wb_vd", wb_vd, q_vd[0]);
        chk("m_sb_busy", sb_busy, sb);
        chk("m_stall_cnt", stall_cnt, m_stall);
        chk("m_err_underflow", err_underflow, m_err);
        chk("m_flush_done", flush_done, m_phase == 2);

        if (rst_n) begin
            if (in_valid && !rdy && m_stall < (1 << CNT_W) - 1) m_stall++;
            if (ex_done && sz == 0) m_err = 1;
            case (m_phase)
                0: if (flush_req) m_phase = 1;
                1: if (sz == 0) m_phase = 2;
                default: m_phase = 0;
            endcase
            if (pp) begin
                void'(q_vd.pop_front());
                void'(q_we.pop_front());
            end
            if (iss) begin
                q_vd.push_back(int'(in_vd));
                q_we.push_back(in_we);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); endtask

    task automatic idle();
        in_valid = 0; ex_done = 0; flush_req = 0; ex_busy = 0;
    endtask

    task automatic op(input int vd, input int vs1, input int vs2, input bit we);
        in_valid  = 1;
        in_vd     = 3'(vd);
        in_vs1    = 3'(vs1);
        in_vs2    = 3'(vs2);
        in_we     = we;
        in_alu_op = 3'(vd + 1);
    endtask

    initial begin
        rst_n = 0;
        idle();
        in_vd = 0; in_vs1 = 0; in_vs2 = 0; in_we = 0; in_alu_op = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // reset state
        smp();
        chk("rst_sb", sb_busy, 8'h00);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_flush_done", flush_done, 0);

        // independent back-to-back ops
        nxt(); op(1, 2, 3, 1); smp(); chk("ind_issue0", ex_valid, 1);
        nxt(); op(4, 5, 6, 1); smp(); chk("ind_issue1", ex_valid, 1);
        chk("ind_alu_op", ex_alu_op, 3'd5);
        nxt(); idle(); smp(); chk("ind_sb", sb_busy, 8'h12);
        nxt(); ex_done = 1; smp(); chk("ind_wb_we", wb_we, 1); chk("ind_wb_vd0", wb_vd, 1);
        nxt(); smp(); chk("ind_wb_vd1", wb_vd, 4);
        nxt(); idle(); smp(); chk("ind_sb_clr", sb_busy, 8'h00);

        // RAW stall until v1 completes
        nxt(); op(1, 2, 3, 1); smp();
        nxt(); op(4, 1, 5, 1); smp(); chk("raw_block", in_ready, 0);
        nxt(); smp();
        nxt(); ex_done = 1; smp();
        chk("raw_no_bypass", in_ready, 0);
        chk("raw_wb_we", wb_we, 1);
        chk("raw_wb_vd", wb_vd, 1);
        nxt(); ex_done = 0; smp();
        chk("raw_issue", ex_valid, 1);
        chk("raw_stall", stall_cnt, 3);
        nxt(); in_valid = 0; ex_done = 1; smp(); chk("raw_wb_vd4", wb_vd, 4);
        nxt(); idle(); smp();

        // full FIFO
        for (int i = 0; i < 4; i++) begin
            nxt(); op(i, 7, 7, 1); smp(); chk("full_fill", ex_valid, 1);
        end
        nxt(); op(5, 7, 7, 1); smp(); chk("full_block", in_ready, 0);
        nxt(); ex_done = 1; smp(); chk("full_done_block", in_ready, 0); chk("full_wb_vd", wb_vd, 0);
        nxt(); ex_done = 0; smp(); chk("full_issue", ex_valid, 1);
        nxt(); idle(); smp();
        chk("full_sb", sb_busy, 8'h2E);
        chk("full_stall", stall_cnt, 5);
        nxt(); ex_done = 1;
        repeat (3) nxt();
        nxt(); idle(); smp(); chk("full_drain_sb", sb_busy, 8'h00);

        // same-index set with a non-writing completion
        nxt(); op(2, 7, 7, 0); smp(); chk("same_issue0", ex_valid, 1);
        nxt(); op(2, 7, 7, 1); ex_done = 1; smp();
        chk("same_issue1", ex_valid, 1);
        chk("same_wb_we", wb_we, 0);
        nxt(); idle(); smp(); chk("same_sb", sb_busy, 8'h04);
        nxt(); ex_done = 1; smp(); chk("same_wb_we1", wb_we, 1); chk("same_wb_vd", wb_vd, 2);
        nxt(); idle(); smp(); chk("same_sb_clr", sb_busy, 8'h00);

        // flush with two in flight
        nxt(); op(1, 2, 3, 1);
        nxt(); op(4, 5, 6, 1);
        nxt(); op(6, 7, 7, 1); flush_req = 1; smp(); chk("fl_block", in_ready, 0);
        nxt(); in_valid = 0; flush_req = 0; ex_done = 1; smp(); chk("fl_drain_rdy", in_ready, 0);
        nxt(); smp();
        nxt(); ex_done = 0; smp(); chk("fl_done_lo", flush_done, 0);
        nxt(); smp(); chk("fl_done_hi", flush_done, 1); chk("fl_done_rdy", in_ready, 0);
        nxt(); smp(); chk("fl_done_end", flush_done, 0); chk("fl_run_rdy", in_ready, 1);
        chk("fl_stall", stall_cnt, 6);

        // underflow and mid-operation reset
        nxt(); idle(); ex_done = 1; smp(); chk("uf_wb_we", wb_we, 0);
        nxt(); ex_done = 0; smp(); chk("uf_err", err_underflow, 1);
        nxt(); op(3, 7, 7, 1); smp();
        nxt(); in_valid = 0; rst_n = 0; smp();
        chk("mrst_sb", sb_busy, 8'h00);
        chk("mrst_err", err_underflow, 0);
        chk("mrst_stall", stall_cnt, 0);
        chk("mrst_ready", in_ready, 1);
        nxt(); rst_n = 1; ex_done = 1; smp(); chk("mrst_uf_wb_we", wb_we, 0);
        nxt(); ex_done = 0; smp(); chk("mrst_uf_err", err_underflow, 1);

        // stall counter saturation
        nxt(); op(0, 7, 7, 0); ex_busy = 1;
        repeat (20) nxt();
        smp(); chk("sat_stall", stall_cnt, 15); chk("sat_ready", in_ready, 0);
        nxt(); idle(); smp(); chk("sat_hold", stall_cnt, 15);

        nxt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
